// File: rtl/ac97_reg_ctrl.sv
// ac97_reg_ctrl: AC97 codec register read/write sequencer driving command slots 1/2
module ac97_reg_ctrl #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        codec_ready,
  input  logic        frame_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        slot_valid,
  output logic [19:0] slot1_out,
  output logic [19:0] slot2_out,
  input  logic        rsp_in_valid,
  input  logic [6:0]  rsp_in_addr,
  input  logic [15:0] rsp_in_data,
  output logic        done,
  output logic        done_err,
  output logic [15:0] rdata,
  output logic        busy
);
  localparam logic [1:0] WAIT_RDY = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] ISSUE    = 2'd2;
  localparam logic [1:0] WAIT_RSP = 2'd3;
  localparam logic [3:0] TO       = 4'(TIMEOUT_FRAMES);
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic [6:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        slot_valid_q, slot_valid_d;
  logic [19:0] slot1_q, slot1_d, slot2_q, slot2_d;
  logic        done_q, done_d, err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        match;
  assign cmd_ready  = (state_q == IDLE) && codec_ready;
  assign busy       = state_q != IDLE;
  assign slot_valid = slot_valid_q;
  assign slot1_out  = slot1_q;
  assign slot2_out  = slot2_q;
  assign done       = done_q;
  assign done_err   = err_q;
  assign rdata      = rdata_q;
  assign cnt_inc    = cnt_q + 4'd1;
  assign match      = rsp_in_valid && (rsp_in_addr == addr_q);
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    slot_valid_d = slot_valid_q;
    slot1_d      = slot1_q;
    slot2_d      = slot2_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      WAIT_RDY: state_d = codec_ready ? IDLE : WAIT_RDY;
      IDLE: begin
        if (!codec_ready) state_d = WAIT_RDY;
        else if (cmd_valid) begin
          state_d      = ISSUE;
          rd_d         = cmd_rd;
          addr_d       = cmd_addr;
          slot_valid_d = 1'b1;
          slot1_d      = {cmd_rd, cmd_addr, 12'h000};
          slot2_d      = cmd_rd ? 20'h00000 : {cmd_wdata, 4'h0};
        end
      end
      ISSUE: begin
        // slots stay put until the link engine has sampled them on a frame_start
        if (!codec_ready || frame_start) begin
          slot_valid_d = 1'b0;
          slot1_d      = 20'h00000;
          slot2_d      = 20'h00000;
        end
        if (!codec_ready) begin
          state_d = WAIT_RDY;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (frame_start) begin
          state_d = rd_q ? WAIT_RSP : IDLE;
          done_d  = !rd_q;
          cnt_d   = 4'd0;
        end
      end
      WAIT_RSP: begin
        if (!codec_ready) begin
          state_d = WAIT_RDY;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (match) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rdata_d = rsp_in_data;
        end else if (frame_start) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 16'h0000;
          end
        end
      end
      default: state_d = WAIT_RDY;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_RDY;
      cnt_q        <= 4'd0;
      addr_q       <= 7'd0;
      rd_q         <= 1'b0;
      slot_valid_q <= 1'b0;
      slot1_q      <= 20'h00000;
      slot2_q      <= 20'h00000;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      slot_valid_q <= slot_valid_d;
      slot1_q      <= slot1_d;
      slot2_q      <= slot2_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule
